// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: redirect input, instruction-memory handshake and decode-side queue head.
// master = fetch unit side, slave = memory/decode/execute side.
interface fetch_unit_if;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rdy;
  logic [15:0] imem_data;
  logic        id_stall;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic [15:0] if_inc_pc;
  logic        halted;
  logic        fetch_err;

  modport master (
    input  redirect, redirect_pc, imem_rdy, imem_data, id_stall,
    output imem_req, imem_addr, if_valid, if_instr, if_pc, if_inc_pc, halted, fetch_err
  );

  modport slave (
    output redirect, redirect_pc, imem_rdy, imem_data, id_stall,
    input  imem_req, imem_addr, if_valid, if_instr, if_pc, if_inc_pc, halted, fetch_err
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, one outstanding imem request, 2-entry queue to decode.
// Optional request timeout guarded by FETCH_TIMEOUT_EN (sticky fetch_err, forces HALT).
module fetch_unit #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [4:0]  HALT_OPCODE = 5'b00000
`ifdef FETCH_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC = 64
`endif
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);

  localparam int unsigned   XW      = 16;
  localparam logic [XW-1:0] PC_STEP = XW'(2);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_SQUASH, S_HALT} state_e;

  state_e        state_q, state_d;
  logic [XW-1:0] pc_q, pc_d, addr_q, addr_d;
  logic          req_q, halted_q;
  logic          hd_v_q, hd_v_d, tl_v_q, tl_v_d;
  logic [XW-1:0] hd_instr_q, hd_instr_d, hd_pc_q, hd_pc_d, hd_inc_q, hd_inc_d;
  logic [XW-1:0] tl_instr_q, tl_instr_d, tl_pc_q, tl_pc_d, tl_inc_q, tl_inc_d;
  logic          pop, push, room, is_halt;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned       TCNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYC - 1);
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic              err_q, err_d;
`endif

  // Queue update, then next state; redirect overrides everything.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    hd_v_d     = hd_v_q;
    hd_instr_d = hd_instr_q;
    hd_pc_d    = hd_pc_q;
    hd_inc_d   = hd_inc_q;
    tl_v_d     = tl_v_q;
    tl_instr_d = tl_instr_q;
    tl_pc_d    = tl_pc_q;
    tl_inc_d   = tl_inc_q;
`ifdef FETCH_TIMEOUT_EN
    tcnt_d     = '0;
    err_d      = err_q;
`endif
    pop     = hd_v_q & ~bus.id_stall;
    push    = (state_q == S_REQ) & bus.imem_rdy & ~bus.redirect;
    is_halt = (bus.imem_data[15:11] == HALT_OPCODE);

    if (bus.redirect) begin
      hd_v_d = 1'b0;
      tl_v_d = 1'b0;
    end else begin
      if (pop) begin
        hd_v_d     = tl_v_q;
        hd_instr_d = tl_instr_q;
        hd_pc_d    = tl_pc_q;
        hd_inc_d   = tl_inc_q;
        tl_v_d     = 1'b0;
      end
      if (push) begin
        if (!hd_v_d) begin
          hd_v_d     = 1'b1;
          hd_instr_d = bus.imem_data;
          hd_pc_d    = pc_q;
          hd_inc_d   = pc_q + PC_STEP;
        end else begin
          tl_v_d     = 1'b1;
          tl_instr_d = bus.imem_data;
          tl_pc_d    = pc_q;
          tl_inc_d   = pc_q + PC_STEP;
        end
      end
    end
    room = ~(hd_v_d & tl_v_d);

    if (bus.redirect) begin
      pc_d = bus.redirect_pc;
      case (state_q)
        S_REQ, S_SQUASH: state_d = bus.imem_rdy ? S_REQ : S_SQUASH;
        default:         state_d = S_REQ;
      endcase
    end else begin
      case (state_q)
        S_IDLE:   if (room) state_d = S_REQ;
        S_REQ:    if (bus.imem_rdy) begin
                    pc_d    = pc_q + PC_STEP;
                    state_d = is_halt ? S_HALT : (room ? S_REQ : S_IDLE);
                  end
        S_SQUASH: if (bus.imem_rdy) state_d = S_REQ;
        default:  state_d = S_HALT;
      endcase
    end

`ifdef FETCH_TIMEOUT_EN
    // Count only uninterrupted waiting in one state; a pending redirect defers the trip.
    if ((state_q == S_REQ || state_q == S_SQUASH) && !bus.imem_rdy && state_d == state_q) begin
      if (tcnt_q >= TCNT_LAST && !bus.redirect) begin
        err_d   = 1'b1;
        state_d = S_HALT;
      end else begin
        tcnt_d = (tcnt_q >= TCNT_LAST) ? tcnt_q : tcnt_q + TCNT_W'(1);
      end
    end
    if (err_q) state_d = S_HALT;
`endif

    addr_d = (state_d == S_REQ) ? pc_d : addr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      addr_q     <= RESET_PC;
      req_q      <= 1'b0;
      halted_q   <= 1'b0;
      hd_v_q     <= 1'b0;
      hd_instr_q <= '0;
      hd_pc_q    <= '0;
      hd_inc_q   <= '0;
      tl_v_q     <= 1'b0;
      tl_instr_q <= '0;
      tl_pc_q    <= '0;
      tl_inc_q   <= '0;
`ifdef FETCH_TIMEOUT_EN
      tcnt_q     <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      req_q      <= (state_d == S_REQ) || (state_d == S_SQUASH);
      halted_q   <= (state_d == S_HALT);
      hd_v_q     <= hd_v_d;
      hd_instr_q <= hd_instr_d;
      hd_pc_q    <= hd_pc_d;
      hd_inc_q   <= hd_inc_d;
      tl_v_q     <= tl_v_d;
      tl_instr_q <= tl_instr_d;
      tl_pc_q    <= tl_pc_d;
      tl_inc_q   <= tl_inc_d;
`ifdef FETCH_TIMEOUT_EN
      tcnt_q     <= tcnt_d;
      err_q      <= err_d;
`endif
    end
  end

  assign bus.imem_req  = req_q;
  assign bus.imem_addr = addr_q;
  assign bus.if_valid  = hd_v_q;
  assign bus.if_instr  = hd_instr_q;
  assign bus.if_pc     = hd_pc_q;
  assign bus.if_inc_pc = hd_inc_q;
  assign bus.halted    = halted_q;
`ifdef FETCH_TIMEOUT_EN
  assign bus.fetch_err = err_q;
`else
  assign bus.fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized phase, checked against a
// program-order model (expected fetch pointer, queue of delivered entries, halt flag).
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst;

  fetch_unit_if bus ();

`ifdef FETCH_TIMEOUT_EN
  fetch_unit #(.TIMEOUT_CYC(8)) dut (.clk(clk), .rst(rst), .bus(bus));
`else
  fetch_unit dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
  } ent_t;

  ent_t        q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          lat = 1;
  int          cur_lat = 1;
  int          wait_n = 0;
  bit          rand_lat = 0;
  bit          blk = 0;
  bit          chk_halt = 1;
  bit          squash, halt_m, halt_seen, prev_req, prev_done;
  logic [15:0] fptr, prev_addr;
  logic [15:0] halt_addr = 16'hFFFF;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (a == halt_addr) return 16'h0000;
    return {1'b1, a[14:0] ^ 15'h35A9};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge: drive inputs, answer memory, check outputs, advance model.
  task automatic tick(input bit redir, input logic [15:0] rpc, input bit stall);
    bit   newr, done, pop;
    ent_t e;
    bus.redirect    = redir;
    bus.redirect_pc = rpc;
    bus.id_stall    = stall;
    if (bus.imem_req === 1'b1) begin
      newr = !prev_req || prev_done;
      if (newr) begin
        wait_n  = 0;
        cur_lat = rand_lat ? int'($urandom_range(1, 4)) : lat;
        if (!squash) chk("req_addr", bus.imem_addr, fptr);
      end else begin
        chk("addr_stable", bus.imem_addr, prev_addr);
      end
      wait_n++;
      bus.imem_rdy  = (wait_n >= cur_lat) && !blk;
      bus.imem_data = bus.imem_rdy ? mem_word(bus.imem_addr) : 16'($urandom);
    end else begin
      bus.imem_rdy  = 1'b0;
      bus.imem_data = 16'h0000;
    end

    chk("if_valid", bus.if_valid, 16'(q.size() != 0));
    if (q.size() != 0) begin
      chk("if_pc", bus.if_pc, q[0].pc);
      chk("if_instr", bus.if_instr, q[0].instr);
      chk("if_inc_pc", bus.if_inc_pc, q[0].pc + 16'd2);
    end
    chk("q_depth", 16'(q.size() <= 2), 16'd1);
    if (chk_halt) begin
      chk("halted", bus.halted, 16'(halt_m));
      chk("fetch_err", bus.fetch_err, 16'd0);
      if (halt_m) chk("halt_noreq", bus.imem_req, 16'd0);
    end

    done = (bus.imem_req === 1'b1) && bus.imem_rdy;
    pop  = (q.size() != 0) && !stall;
    if (pop && q[0].instr[15:11] == 5'b00000) halt_seen = 1;
    if (redir) begin
      q.delete();
      fptr   = rpc;
      halt_m = 0;
      squash = (bus.imem_req === 1'b1) && !done;
    end else begin
      if (pop) void'(q.pop_front());
      if (done) begin
        if (squash) begin
          squash = 0;
        end else begin
          e.pc    = bus.imem_addr;
          e.instr = bus.imem_data;
          q.push_back(e);
          fptr = bus.imem_addr + 16'd2;
          if (bus.imem_data[15:11] == 5'b00000) halt_m = 1;
        end
      end
    end
    prev_req  = (bus.imem_req === 1'b1);
    prev_addr = bus.imem_addr;
    prev_done = done;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst             = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 16'h0000;
    bus.id_stall    = 1'b0;
    bus.imem_rdy    = 1'b0;
    bus.imem_data   = 16'h0000;
    q.delete();
    fptr = 16'h0000; squash = 0; halt_m = 0; halt_seen = 0;
    prev_req = 0; prev_done = 0; prev_addr = 16'h0000; wait_n = 0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_req", bus.imem_req, 16'd0);
    chk("rst_valid", bus.if_valid, 16'd0);
    chk("rst_instr", bus.if_instr, 16'd0);
    chk("rst_pc", bus.if_pc, 16'd0);
    chk("rst_inc", bus.if_inc_pc, 16'd0);
    chk("rst_halted", bus.halted, 16'd0);
    chk("rst_err", bus.fetch_err, 16'd0);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    rst = 1'b1;

    // 1-cycle memory: back-to-back requests.
    do_reset();
    lat = 1;
    chk("t1_req", bus.imem_req, 16'd1);
    chk("t1_addr0", bus.imem_addr, 16'h0000);
    tick(0, 0, 0);
    chk("t1_addr2", bus.imem_addr, 16'h0002);
    tick(0, 0, 0);
    chk("t1_addr4", bus.imem_addr, 16'h0004);
    for (int i = 0; i < 6; i++) tick(0, 0, 0);

    // Reset in the middle of a request.
    do_reset();
    lat = 3;
    tick(0, 0, 0);
    tick(0, 0, 0);
    rst = 1'b1;
    #1;
    chk("mid_rst_req", bus.imem_req, 16'd0);
    chk("mid_rst_valid", bus.if_valid, 16'd0);
    do_reset();

    // Latency 3 with decode stalled: queue fills, requests stop.
    for (int i = 0; i < 10; i++) tick(0, 0, 1);
    chk("t2_req_off", bus.imem_req, 16'd0);
    chk("t2_depth", 16'(q.size()), 16'd2);
    chk("t2_head", bus.if_pc, 16'h0000);
    for (int i = 0; i < 12; i++) tick(0, 0, 0);

    // Redirect in the 2nd cycle of the request to 0x0004.
    do_reset();
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (bus.imem_req === 1'b1 && bus.imem_addr === 16'h0004) found = 1;
      else tick(0, 0, 0);
    end
    chk("t3_req4_seen", 16'(found), 16'd1);
    tick(0, 0, 0);
    tick(1, 16'h0040, 0);
    chk("t3_flush", bus.if_valid, 16'd0);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (bus.imem_req === 1'b1 && bus.imem_addr === 16'h0040) found = 1;
      else tick(0, 0, 0);
    end
    chk("t3_req40_seen", 16'(found), 16'd1);
    for (int i = 0; i < 8; i++) tick(0, 0, 0);

    // HALT fetched from 0x0006, then resumed by a redirect.
    do_reset();
    lat = 1;
    halt_addr = 16'h0006;
    for (int i = 0; i < 12; i++) tick(0, 0, 0);
    chk("t4_halted", bus.halted, 16'd1);
    chk("t4_noreq", bus.imem_req, 16'd0);
    chk("t4_delivered", 16'(halt_seen), 16'd1);
    tick(1, 16'h0100, 0);
    chk("t4_resume_addr", bus.imem_addr, 16'h0100);
    chk("t4_unhalted", bus.halted, 16'd0);
    halt_addr = 16'hFFFF;
    for (int i = 0; i < 4; i++) tick(0, 0, 0);

    // PC wrap at 0xFFFE.
    tick(1, 16'hFFFC, 0);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (bus.if_valid === 1'b1 && bus.if_pc === 16'hFFFE) found = 1;
      else tick(0, 0, 0);
    end
    chk("t5_head_seen", 16'(found), 16'd1);
    chk("t5_inc_wrap", bus.if_inc_pc, 16'h0000);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (bus.imem_req === 1'b1 && bus.imem_addr === 16'h0000) found = 1;
      else tick(0, 0, 0);
    end
    chk("t5_req0_seen", 16'(found), 16'd1);

    // Randomized traffic: latency, stalls, redirects (some odd, some near the wrap), halts.
    rand_lat  = 1;
    halt_addr = 16'h0030;
    for (int i = 0; i < 600; i++) begin
      bit          r;
      logic [15:0] t;
      r = ($urandom_range(0, 24) == 0);
      t = ($urandom_range(0, 7) == 0) ? 16'hFFF0 + 16'($urandom_range(0, 15))
                                      : 16'($urandom_range(0, 127));
      tick(r, t, $urandom_range(0, 3) == 0);
    end
    rand_lat  = 0;
    halt_addr = 16'hFFFF;

`ifdef FETCH_TIMEOUT_EN
    // Memory never answers: error and halt after 8 request cycles, held until reset.
    do_reset();
    blk = 1;
    chk_halt = 0;
    for (int i = 0; i < 8; i++) tick(0, 0, 0);
    chk("t6_err", bus.fetch_err, 16'd1);
    chk("t6_halted", bus.halted, 16'd1);
    chk("t6_noreq", bus.imem_req, 16'd0);
    tick(1, 16'h0100, 0);
    for (int i = 0; i < 3; i++) tick(0, 0, 0);
    chk("t6_err_sticky", bus.fetch_err, 16'd1);
    chk("t6_halt_sticky", bus.halted, 16'd1);
    chk("t6_noreq_sticky", bus.imem_req, 16'd0);
    blk = 0;
    chk_halt = 1;
    do_reset();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
